xosera_main_core: RTL and testbench



---
 rtl/xosera_main_core.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_xosera_main_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xosera_main_core.sv
// xosera_main_core
//
// Top-level core of the Xosera video controller, single pixel-clock domain.
//   - 8-bit 68K-style bus slave in front of a 16-bit register file
//   - 64K x 16 internal VRAM reached through auto-incrementing read/write
//     address registers (reads are prefetched into rd_data)
//   - VGA timing generator producing registered RGB444, hsync, vsync, dv_en
//   - two 8-bit PWM audio channels sharing one free-running counter
//
// Ports:
//   clk                  pixel clock
//   reset_i              synchronous, active-high reset
//   red_o/green_o/blue_o 4-bit colour, 0 outside the visible area
//   hsync_o, vsync_o     sync outputs (active level set by *_SYNC_POLARITY)
//   dv_en_o              high in the visible area
//   bus_cs_n_i           asynchronous chip select, active low
//   bus_rd_nwr_i         1 = read, 0 = write
//   bus_reg_num_i        register number
//   bus_bytesel_i        0 = high byte, 1 = low byte
//   bus_data_i           write data byte
//   bus_data_o           read data byte (combinational from reg_num/bytesel)
//   audio_l_o, audio_r_o PWM audio
//
// Bus protocol: there is no valid/ready handshake. The host holds reg_num,
// bytesel, rd_nwr and data stable while cs_n is low. The synchronised
// falling edge of cs_n yields exactly one internal strobe per assertion,
// which captures the bus fields; one clock later the captured cycle is
// executed as either bus_write_strobe or bus_read_strobe.

module xosera_main_core #(
    parameter int   H_VISIBLE       = 640,
    parameter int   H_FRONT         = 16,
    parameter int   H_SYNC          = 96,
    parameter int   H_BACK          = 48,
    parameter int   V_VISIBLE       = 480,
    parameter int   V_FRONT         = 10,
    parameter int   V_SYNC          = 2,
    parameter int   V_BACK          = 33,
    parameter logic H_SYNC_POLARITY = 1'b0,
    parameter logic V_SYNC_POLARITY = 1'b0
) (
    input  logic       clk,
    input  logic       reset_i,
    output logic [3:0] red_o,
    output logic [3:0] green_o,
    output logic [3:0] blue_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       dv_en_o,
    input  logic       bus_cs_n_i,
    input  logic       bus_rd_nwr_i,
    input  logic [3:0] bus_reg_num_i,
    input  logic       bus_bytesel_i,
    input  logic [7:0] bus_data_i,
    output logic [7:0] bus_data_o,
    output logic       audio_l_o,
    output logic       audio_r_o
);

    // ------------------------------------------------------------------
    // Register numbers
    // ------------------------------------------------------------------
    localparam logic [3:0] REG_RD_ADDR   = 4'h0;
    localparam logic [3:0] REG_WR_ADDR   = 4'h1;
    localparam logic [3:0] REG_DATA      = 4'h2;
    localparam logic [3:0] REG_RD_INC    = 4'h3;
    localparam logic [3:0] REG_WR_INC    = 4'h4;
    localparam logic [3:0] REG_VID_COLOR = 4'h5;
    localparam logic [3:0] REG_AUDIO     = 4'h6;
    localparam logic [3:0] REG_STATUS    = 4'h7;

    // ------------------------------------------------------------------
    // Video timing constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------
    // Bus synchroniser and strobe generation
    // ------------------------------------------------------------------
    logic cs_s1;
    logic cs_s2;
    logic cs_prev;
    logic cs_strobe;

    // Reset forces the chain to the "selected" level, so a cycle that was in
    // flight at reset cannot produce a strobe until cs_n goes high and then
    // falls again.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_prev <= 1'b0;
        end else begin
            cs_s1   <= bus_cs_n_i;
            cs_s2   <= cs_s1;
            cs_prev <= cs_s2;
        end
    end

    assign cs_strobe = cs_prev & ~cs_s2;

    logic        bus_strobe_q;
    logic        bus_rd_nwr;
    logic [3:0]  bus_reg_num;
    logic        bus_bytesel;
    logic [15:0] bus_data_write;
    logic [7:0]  data_latch;
    logic        bus_write_strobe;
    logic        bus_read_strobe;

    // Bus fields have been stable for several clocks by the time the strobe
    // fires, so sampling them directly here is safe.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            bus_strobe_q   <= 1'b0;
            bus_rd_nwr     <= 1'b0;
            bus_reg_num    <= 4'h0;
            bus_bytesel    <= 1'b0;
            bus_data_write <= 16'h0000;
        end else begin
            bus_strobe_q <= cs_strobe;
            if (cs_strobe) begin
                bus_rd_nwr     <= bus_rd_nwr_i;
                bus_reg_num    <= bus_reg_num_i;
                bus_bytesel    <= bus_bytesel_i;
                // Low-byte writes commit {latch, byte}; high-byte writes
                // only use the low half to refill the latch.
                bus_data_write <= {data_latch, bus_data_i};
            end
        end
    end

    assign bus_write_strobe = bus_strobe_q & ~bus_rd_nwr;
    assign bus_read_strobe  = bus_strobe_q &  bus_rd_nwr;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [15:0] reg_rd_addr;
    logic [15:0] reg_wr_addr;
    logic [15:0] reg_rd_inc;
    logic [15:0] reg_wr_inc;
    logic [11:0] reg_vid_color;
    logic [15:0] reg_audio;
    logic [15:0] rd_data;
    logic        prefetch_req;
    logic        prefetch_valid;
    logic        mem_we;

    assign mem_we = bus_write_strobe & bus_bytesel & (bus_reg_num == REG_DATA);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            reg_rd_addr   <= 16'h0000;
            reg_wr_addr   <= 16'h0000;
            reg_rd_inc    <= 16'h0001;
            reg_wr_inc    <= 16'h0001;
            reg_vid_color <= 12'h000;
            reg_audio     <= 16'h0000;
            data_latch    <= 8'h00;
            prefetch_req  <= 1'b0;
        end else begin
            prefetch_req <= 1'b0;
            if (bus_write_strobe) begin
                if (!bus_bytesel) begin
                    data_latch <= bus_data_write[7:0];
                end else begin
                    case (bus_reg_num)
                        REG_RD_ADDR: begin
                            reg_rd_addr  <= bus_data_write;
                            prefetch_req <= 1'b1;
                        end
                        REG_WR_ADDR:   reg_wr_addr   <= bus_data_write;
                        REG_DATA:      reg_wr_addr   <= reg_wr_addr + reg_wr_inc;
                        REG_RD_INC:    reg_rd_inc    <= bus_data_write;
                        REG_WR_INC:    reg_wr_inc    <= bus_data_write;
                        REG_VID_COLOR: reg_vid_color <= bus_data_write[11:0];
                        REG_AUDIO:     reg_audio     <= bus_data_write;
                        default: ;
                    endcase
                end
            end
            // Finishing a DATA word read advances the read pointer and
            // fetches the next word so it is ready for the following read.
            if (bus_read_strobe && bus_bytesel && (bus_reg_num == REG_DATA)) begin
                reg_rd_addr  <= reg_rd_addr + reg_rd_inc;
                prefetch_req <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // VRAM: write on the strobe clock, read one clock later, so a prefetch
    // always observes writes executed by earlier bus cycles.
    // ------------------------------------------------------------------
    logic [15:0] memory [65536];
    logic [15:0] mem_dout;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            memory[reg_wr_addr] <= bus_data_write;
        end
        if (prefetch_req) begin
            mem_dout <= memory[reg_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            prefetch_valid <= 1'b0;
            rd_data        <= 16'h0000;
        end else begin
            prefetch_valid <= prefetch_req;
            if (prefetch_valid) begin
                rd_data <= mem_dout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Video timing
    // ------------------------------------------------------------------
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          h_blank;
    logic          v_blank;
    logic          visible;
    logic          h_sync_win;
    logic          v_sync_win;

    assign h_blank    = (h_count >= H_VIS_END);
    assign v_blank    = (v_count >= V_VIS_END);
    assign visible    = ~h_blank & ~v_blank;
    assign h_sync_win = (h_count >= H_SYNC_START) && (h_count < H_SYNC_END);
    assign v_sync_win = (v_count >= V_SYNC_START) && (v_count < V_SYNC_END);

    // All video outputs are registered from the same count, so they share
    // one clock of latency relative to h_count/v_count.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            h_count <= '0;
            v_count <= '0;
            hsync_o <= ~H_SYNC_POLARITY;
            vsync_o <= ~V_SYNC_POLARITY;
            dv_en_o <= 1'b0;
            red_o   <= 4'h0;
            green_o <= 4'h0;
            blue_o  <= 4'h0;
        end else begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                if (v_count == V_LAST) begin
                    v_count <= '0;
                end else begin
                    v_count <= v_count + 1'b1;
                end
            end else begin
                h_count <= h_count + 1'b1;
            end
            hsync_o <= h_sync_win ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
            vsync_o <= v_sync_win ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
            dv_en_o <= visible;
            red_o   <= visible ? reg_vid_color[11:8] : 4'h0;
            green_o <= visible ? reg_vid_color[7:4]  : 4'h0;
            blue_o  <= visible ? reg_vid_color[3:0]  : 4'h0;
        end
    end

    // ------------------------------------------------------------------
    // Audio PWM: duty N gives N high clocks out of every 256.
    // ------------------------------------------------------------------
    logic [7:0] audio_cnt;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            audio_cnt <= 8'h00;
            audio_l_o <= 1'b0;
            audio_r_o <= 1'b0;
        end else begin
            audio_cnt <= audio_cnt + 8'h01;
            audio_l_o <= (audio_cnt < reg_audio[15:8]);
            audio_r_o <= (audio_cnt < reg_audio[7:0]);
        end
    end

    // ------------------------------------------------------------------
    // Read mux: driven straight from the live bus inputs so the host sees
    // data while cs_n is still low.
    // ------------------------------------------------------------------
    logic [15:0] read_word;

    always_comb begin
        read_word = 16'h0000;
        case (bus_reg_num_i)
            REG_RD_ADDR:   read_word = reg_rd_addr;
            REG_WR_ADDR:   read_word = reg_wr_addr;
            REG_DATA:      read_word = rd_data;
            REG_RD_INC:    read_word = reg_rd_inc;
            REG_WR_INC:    read_word = reg_wr_inc;
            REG_VID_COLOR: read_word = {4'h0, reg_vid_color};
            REG_AUDIO:     read_word = reg_audio;
            REG_STATUS:    read_word = {v_blank, h_blank, 14'h0000};
            default:       read_word = 16'h0000;
        endcase
        bus_data_o = bus_bytesel_i ? read_word[7:0] : read_word[15:8];
    end

endmodule

// File: tb/tb_xosera_main_core.sv
// Testbench for xosera_main_core. Horizontal timing uses the default
// 800-clock line; vertical timing is shortened to 13 lines per frame so
// that three whole frames fit in a short run.

module tb_xosera_main_core;

    localparam int H_VIS   = 640;
    localparam int H_TOT   = 800;
    localparam int H_SYN   = 96;
    localparam int V_VIS   = 6;
    localparam int V_FP    = 2;
    localparam int V_SYN   = 2;
    localparam int V_BP    = 3;
    localparam int V_TOT   = V_VIS + V_FP + V_SYN + V_BP;
    localparam int FRAME   = H_TOT * V_TOT;
    localparam int NFRAMES = 3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_i;
    logic [3:0] red_o, green_o, blue_o;
    logic       hsync_o, vsync_o, dv_en_o;
    logic       bus_cs_n_i;
    logic       bus_rd_nwr_i;
    logic [3:0] bus_reg_num_i;
    logic       bus_bytesel_i;
    logic [7:0] bus_data_i;
    logic [7:0] bus_data_o;
    logic       audio_l_o, audio_r_o;

    always #5 clk = ~clk;

    xosera_main_core #(
        .V_VISIBLE (V_VIS),
        .V_FRONT   (V_FP),
        .V_SYNC    (V_SYN),
        .V_BACK    (V_BP)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .red_o         (red_o),
        .green_o       (green_o),
        .blue_o        (blue_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .dv_en_o       (dv_en_o),
        .bus_cs_n_i    (bus_cs_n_i),
        .bus_rd_nwr_i  (bus_rd_nwr_i),
        .bus_reg_num_i (bus_reg_num_i),
        .bus_bytesel_i (bus_bytesel_i),
        .bus_data_i    (bus_data_i),
        .bus_data_o    (bus_data_o),
        .audio_l_o     (audio_l_o),
        .audio_r_o     (audio_r_o)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_cycle(input logic rd, input logic [3:0] rn, input logic bs,
                             input logic [7:0] d, output logic [7:0] q);
        @(negedge clk);
        bus_rd_nwr_i  = rd;
        bus_reg_num_i = rn;
        bus_bytesel_i = bs;
        bus_data_i    = d;
        bus_cs_n_i    = 1'b0;
        // sample before this cycle's strobe can change anything
        repeat (2) @(negedge clk);
        q = bus_data_o;
        repeat (5) @(negedge clk);
        bus_cs_n_i = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic write_word(input logic [3:0] rn, input logic [15:0] w);
        logic [7:0] dummy;
        bus_cycle(1'b0, rn, 1'b0, w[15:8], dummy);
        bus_cycle(1'b0, rn, 1'b1, w[7:0], dummy);
    endtask

    task automatic read_word(input logic [3:0] rn, output logic [15:0] w);
        logic [7:0] hi, lo;
        bus_cycle(1'b1, rn, 1'b0, 8'h00, hi);
        bus_cycle(1'b1, rn, 1'b1, 8'h00, lo);
        w = {hi, lo};
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] w;
    logic [7:0]  b;
    int dv_cnt, hs_low, vs_low, hs_fall, vs_fall, hs_bad_int, vs_bad_int;
    int vb_cnt, hb_cnt, rgb_ok, rgb_bad, vb_conflict, last_hs, last_vs;
    int al_cnt, ar_cnt;
    logic prev_hs, prev_vs;

    initial begin
        reset_i       = 1'b1;
        bus_cs_n_i    = 1'b1;
        bus_rd_nwr_i  = 1'b1;
        bus_reg_num_i = 4'h0;
        bus_bytesel_i = 1'b0;
        bus_data_i    = 8'h00;
        repeat (4) @(negedge clk);

        // reset state of the outputs
        check_val("rst_hsync", hsync_o, 1'b1);
        check_val("rst_vsync", vsync_o, 1'b1);
        check_val("rst_dv_en", dv_en_o, 1'b0);
        check_val("rst_rgb", {red_o, green_o, blue_o}, 12'h000);
        check_val("rst_audio", {audio_l_o, audio_r_o}, 2'b00);
        reset_i = 1'b0;
        repeat (4) @(negedge clk);

        // reset register values through the bus
        read_word(4'h0, w); check_val("rst_rd_addr", w, 16'h0000);
        read_word(4'h1, w); check_val("rst_wr_addr", w, 16'h0000);
        read_word(4'h3, w); check_val("rst_rd_inc", w, 16'h0001);
        read_word(4'h4, w); check_val("rst_wr_inc", w, 16'h0001);
        read_word(4'h5, w); check_val("rst_color", w, 16'h0000);
        read_word(4'h6, w); check_val("rst_audio_reg", w, 16'h0000);
        bus_cycle(1'b1, 4'h2, 1'b0, 8'h00, b); check_val("rst_data_hi", b, 8'h00);

        // reset in the middle of a WR_ADDR low-byte write abandons it
        @(negedge clk);
        bus_rd_nwr_i  = 1'b0;
        bus_reg_num_i = 4'h1;
        bus_bytesel_i = 1'b1;
        bus_data_i    = 8'h77;
        bus_cs_n_i    = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        repeat (8) @(negedge clk);
        bus_cs_n_i = 1'b1;
        repeat (5) @(negedge clk);
        read_word(4'h1, w); check_val("rst_abort_wr_addr", w, 16'h0000);

        // registers 8-F ignore writes and read 0
        write_word(4'h9, 16'h1234);
        read_word(4'h9, w); check_val("reg9_read", w, 16'h0000);

        // basic VRAM write / prefetch read
        write_word(4'h1, 16'hABCD);
        write_word(4'h2, 16'hDA7A);
        write_word(4'h0, 16'hABCD);
        bus_cycle(1'b1, 4'h2, 1'b0, 8'h00, b); check_val("data_hi", b, 8'hDA);
        bus_cycle(1'b1, 4'h2, 1'b1, 8'h00, b); check_val("data_lo", b, 8'h7A);
        read_word(4'h1, w); check_val("wr_addr_inc", w, 16'hABCE);
        read_word(4'h0, w); check_val("rd_addr_inc", w, 16'hABCE);

        // write address wrap at 0xFFFF
        write_word(4'h1, 16'hFFFF);
        write_word(4'h2, 16'h1111);
        write_word(4'h2, 16'h2222);
        read_word(4'h1, w); check_val("wr_addr_wrap", w, 16'h0001);
        write_word(4'h0, 16'hFFFF);
        read_word(4'h2, w); check_val("mem_ffff", w, 16'h1111);
        read_word(4'h2, w); check_val("mem_0000", w, 16'h2222);

        // RD_INC = 2 skips every other word
        write_word(4'h1, 16'h0010);
        write_word(4'h2, 16'hA0A0);
        write_word(4'h2, 16'hBBBB);
        write_word(4'h2, 16'h1212);
        write_word(4'h3, 16'h0002);
        write_word(4'h0, 16'h0010);
        exp_q.push_back(16'hA0A0);
        exp_q.push_back(16'h1212);
        while (exp_q.size() > 0) begin
            read_word(4'h2, w);
            check_val("rd_inc2_data", w, exp_q.pop_front());
        end
        read_word(4'h0, w); check_val("rd_inc2_addr", w, 16'h0014);

        // a lone high-byte write only fills the latch
        bus_cycle(1'b0, 4'h4, 1'b0, 8'h55, b);
        read_word(4'h4, w); check_val("wr_inc_hi_only", w, 16'h0001);
        bus_cycle(1'b0, 4'h4, 1'b1, 8'h03, b);
        read_word(4'h4, w); check_val("wr_inc_latch_lo", w, 16'h5503);

        // colour register keeps 12 bits
        write_word(4'h5, 16'hFABC);
        read_word(4'h5, w); check_val("color_read", w, 16'h0ABC);

        // three frames of video timing, STATUS watched combinationally
        bus_rd_nwr_i  = 1'b1;
        bus_reg_num_i = 4'h7;
        bus_bytesel_i = 1'b0;
        @(negedge clk);
        prev_hs = hsync_o;
        prev_vs = vsync_o;
        dv_cnt = 0; hs_low = 0; vs_low = 0; hs_fall = 0; vs_fall = 0;
        hs_bad_int = 0; vs_bad_int = 0; vb_cnt = 0; hb_cnt = 0;
        rgb_ok = 0; rgb_bad = 0; vb_conflict = 0; last_hs = -1; last_vs = -1;
        for (int i = 0; i < NFRAMES * FRAME; i++) begin
            @(negedge clk);
            if (dv_en_o) dv_cnt++;
            if (!hsync_o) hs_low++;
            if (!vsync_o) vs_low++;
            if (prev_hs && !hsync_o) begin
                hs_fall++;
                if (last_hs >= 0 && (i - last_hs) != H_TOT) hs_bad_int++;
                last_hs = i;
            end
            if (prev_vs && !vsync_o) begin
                vs_fall++;
                if (last_vs >= 0 && (i - last_vs) != FRAME) vs_bad_int++;
                last_vs = i;
            end
            if (bus_data_o[7]) vb_cnt++;
            if (bus_data_o[6]) hb_cnt++;
            if (dv_en_o && bus_data_o[7]) vb_conflict++;
            if (dv_en_o && {red_o, green_o, blue_o} == 12'hABC) rgb_ok++;
            if (!dv_en_o && {red_o, green_o, blue_o} != 12'h000) rgb_bad++;
            prev_hs = hsync_o;
            prev_vs = vsync_o;
        end
        check_val("dv_en_count", dv_cnt, NFRAMES * H_VIS * V_VIS);
        check_val("hsync_low_clks", hs_low, NFRAMES * V_TOT * H_SYN);
        check_val("hsync_falls", hs_fall, NFRAMES * V_TOT);
        check_val("line_period", hs_bad_int, 0);
        check_val("vsync_low_clks", vs_low, NFRAMES * V_SYN * H_TOT);
        check_val("vsync_falls", vs_fall, NFRAMES);
        check_val("frame_period", vs_bad_int, 0);
        check_val("status_vblank", vb_cnt, NFRAMES * (V_TOT - V_VIS) * H_TOT);
        check_val("status_hblank", hb_cnt, NFRAMES * V_TOT * (H_TOT - H_VIS));
        check_val("vblank_in_visible", vb_conflict, 0);
        check_val("rgb_visible", rgb_ok, NFRAMES * H_VIS * V_VIS);
        check_val("rgb_blank", rgb_bad, 0);

        // audio PWM
        write_word(4'h6, 16'h4000);
        read_word(4'h6, w); check_val("audio_read", w, 16'h4000);
        al_cnt = 0; ar_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (audio_l_o) al_cnt++;
            if (audio_r_o) ar_cnt++;
        end
        check_val("audio_l_40", al_cnt, 128);
        check_val("audio_r_00", ar_cnt, 0);

        write_word(4'h6, 16'h01FF);
        repeat (4) @(negedge clk);
        al_cnt = 0; ar_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (audio_l_o) al_cnt++;
            if (audio_r_o) ar_cnt++;
        end
        check_val("audio_l_01", al_cnt, 2);
        check_val("audio_r_ff", ar_cnt, 510);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
